// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the iterative 16-bit divider.
//                Optional feature macro: DIV_SIGNED_EN (signed operation).
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Operand/result width the divider is built and verified for.
    localparam int DIV_W = 16;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = 16'hFFFF;

    // Controller states; PRE and POST are only visited in the signed build.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        ZERO = 3'd2,
        PRE  = 3'd3,
        POST = 3'd4,
        DONE = 3'd5
    } div_state_t;

    // Two's-complement magnitude; 16'h8000 maps to itself, which reads
    // correctly as the unsigned magnitude 32768.
    function automatic logic [DIV_W-1:0] div_abs(input logic [DIV_W-1:0] v);
        return v[DIV_W-1] ? (-v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_16b_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_16b_seq_if
//  Description : Request/result bundle of the iterative divider.
//                Optional feature macro: DIV_SIGNED_EN (adds the ovf flag).
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_16b_seq_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
`ifdef DIV_SIGNED_EN
    logic         ovf;
`endif

    // Requesting side (EX stage / bench).
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
`ifdef DIV_SIGNED_EN
        , input ovf
`endif
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
`ifdef DIV_SIGNED_EN
        , output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/div_sub_17b.sv
`default_nettype none
// ============================================================================
//  Module      : div_sub_17b
//  Description : Combinational trial subtraction for one restoring-division
//                step. borrow is the top bit of the N-bit difference; it is
//                set exactly when the shifted partial remainder is smaller
//                than the divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_sub_17b #(
    parameter int N = 17
) (
    input  wire logic [N-1:0] a,
    input  wire logic [N-1:0] b,
    output logic      [N-2:0] diff,
    output logic              borrow
);

    // Plain N-bit subtract, split into the kept low bits and the sign bit.
    assign {borrow, diff} = a - b;

endmodule
`default_nettype wire

// File: rtl/div_16b_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_16b_seq
//  Description : Iterative restoring divider, one quotient bit per cycle.
//                Unsigned by default; define DIV_SIGNED_EN for two's
//                complement operands (adds PRE/POST states and ovf).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_16b_seq
    import div_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int CNT_W = 5
) (
    input  wire logic     clk,
    input  wire logic     rst,
    div_16b_seq_if.slave  bus
);

    // State after the last iteration: straight to DONE, or via sign fix-up.
`ifdef DIV_SIGNED_EN
    localparam div_state_t c_after_calc = POST;
    localparam div_state_t c_first_calc = PRE;
`else
    localparam div_state_t c_after_calc = DONE;
    localparam div_state_t c_first_calc = CALC;
`endif

    div_state_t   r_state;
    div_state_t   w_state_nxt;
    div_state_t   w_start_state;

    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_q;        // dividend bits shifting out, quotient in
    logic [W-1:0]     r_rem;      // partial remainder, always < divisor
    logic [W-1:0]     r_dvsr;

    logic [W-1:0]     r_quot;
    logic [W-1:0]     r_rmd;
    logic             r_dz;

`ifdef DIV_SIGNED_EN
    logic             r_neg_q;    // operand signs differ
    logic             r_neg_r;    // dividend negative
    logic             r_ovf_pend;
    logic             r_ovf;
`endif

    logic             w_accept;
    logic             w_last;
    logic [W:0]       w_shift;
    logic [W-1:0]     w_diff;
    logic             w_borrow;
    logic [W-1:0]     w_q_nxt;
    logic [W-1:0]     w_rem_nxt;

    // Start is honoured only when no division is in flight.
    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == CALC) && (r_cnt == CNT_W'(W-1));

    // Shift the next dividend bit into the 17-bit partial remainder.
    assign w_shift  = {r_rem, r_q[W-1]};

    div_sub_17b #(
        .N (W+1)
    ) u_sub (
        .a      (w_shift),
        .b      ({1'b0, r_dvsr}),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    // Keep the difference when it did not go negative; restore otherwise.
    assign w_q_nxt   = {r_q[W-2:0], ~w_borrow};
    assign w_rem_nxt = w_borrow ? w_shift[W-1:0] : w_diff;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; divide-by-zero bypasses the iteration entirely.
    always_comb begin
        w_start_state = (bus.divisor == '0) ? ZERO : c_first_calc;
        w_state_nxt   = r_state;
        case (r_state)
            IDLE: if (bus.start) w_state_nxt = w_start_state;
            DONE: w_state_nxt = bus.start ? w_start_state : IDLE;
            CALC: if (w_last) w_state_nxt = c_after_calc;
            ZERO: w_state_nxt = DONE;
`ifdef DIV_SIGNED_EN
            PRE:  w_state_nxt = CALC;
            POST: w_state_nxt = DONE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture and the iterative shift/subtract datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_dvsr <= '0;
`ifdef DIV_SIGNED_EN
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_ovf_pend <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_q    <= bus.dividend;
            r_rem  <= '0;
            r_dvsr <= bus.divisor;
`ifdef DIV_SIGNED_EN
            r_neg_q    <= bus.dividend[W-1] ^ bus.divisor[W-1];
            r_neg_r    <= bus.dividend[W-1];
            r_ovf_pend <= (bus.dividend == {1'b1, {(W-1){1'b0}}}) &&
                          (bus.divisor == '1);
`endif
        end else begin
            case (r_state)
`ifdef DIV_SIGNED_EN
                PRE: begin
                    r_q    <= W'(div_abs(DIV_W'(r_q)));
                    r_dvsr <= W'(div_abs(DIV_W'(r_dvsr)));
                end
`endif
                CALC: begin
                    r_q   <= w_q_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: written only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot <= '0;
            r_rmd  <= '0;
            r_dz   <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_ovf  <= 1'b0;
`endif
        end else if (r_state == ZERO) begin
            // r_q still holds the raw dividend on this path.
            r_quot <= W'(DIV_ZERO_QUOT);
            r_rmd  <= r_q;
            r_dz   <= 1'b1;
`ifdef DIV_SIGNED_EN
            r_ovf  <= 1'b0;
        end else if (r_state == POST) begin
            r_quot <= r_neg_q ? (-r_q) : r_q;
            r_rmd  <= r_neg_r ? (-r_rem) : r_rem;
            r_dz   <= 1'b0;
            r_ovf  <= r_ovf_pend;
`else
        end else if (w_last) begin
            r_quot <= w_q_nxt;
            r_rmd  <= w_rem_nxt;
            r_dz   <= 1'b0;
`endif
        end
    end

    assign bus.busy      = (r_state == CALC) || (r_state == ZERO) ||
                           (r_state == PRE)  || (r_state == POST);
    assign bus.done      = (r_state == DONE);
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rmd;
    assign bus.div_zero  = r_dz;
`ifdef DIV_SIGNED_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule
`default_nettype wire
